// File: rtl/switch_bank_ctrl_if.sv
// ----------------------------------------------------------------------------
// switch_bank_ctrl_if
//
// Control side of the 8-bit microprocessor bus as seen by switch_bank_ctrl.
// The shared tristate data bus (BUS_DATA) is kept as a plain inout port on the
// peripheral so every driver on it resolves at the top level.
//
// Signals:
//   BUS_ADDR             8  bus address (processor -> peripheral)
//   BUS_WE               1  write strobe, high = write, low = read
//   BUS_INTERRUPT_RAISE  1  level interrupt request (peripheral -> processor)
//   BUS_INTERRUPT_ACK    1  one-cycle acknowledge pulse (processor -> peripheral)
//
// Modports:
//   master  processor side
//   slave   peripheral side
// ----------------------------------------------------------------------------
interface switch_bank_ctrl_if;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       BUS_INTERRUPT_RAISE;
    logic       BUS_INTERRUPT_ACK;

    modport master (
        output BUS_ADDR,
        output BUS_WE,
        output BUS_INTERRUPT_ACK,
        input  BUS_INTERRUPT_RAISE
    );

    modport slave (
        input  BUS_ADDR,
        input  BUS_WE,
        input  BUS_INTERRUPT_ACK,
        output BUS_INTERRUPT_RAISE
    );
endinterface

// File: rtl/switch_bank_ctrl.sv
// ----------------------------------------------------------------------------
// switch_bank_ctrl
//
// Bus-mapped slide-switch / button peripheral. Up to four 8-bit banks of raw
// asynchronous inputs are synchronised (and optionally debounced) into VALUE
// registers; every VALUE toggle latches a sticky CHANGE flag, and toggles on
// interrupt-enabled bits raise a level interrupt until acknowledged.
//
// Register window (b = 0..NUM_BANKS-1), starting at BASE_ADDR:
//   BASE_ADDR + b               VALUE[b]   read-only debounced state
//   BASE_ADDR + NUM_BANKS + b   CHANGE[b]  sticky flags, write 1 to clear
//   BASE_ADDR + 2*NUM_BANKS + b IEN[b]     interrupt enable, read/write
//
// Ports:
//   CLK       system clock
//   RESET     asynchronous active-low reset
//   SWITCHES  raw inputs, bank b = bits [8b+7:8b]
//   BUS_DATA  shared data bus, driven only for reads inside the window
//   bus       switch_bank_ctrl_if.slave (address, write strobe, irq, ack)
//
// Build option:
//   SWITCH_DEBOUNCE_EN  when defined, a shared prescaler (TICK_DIV cycles per
//                       tick) and a 4-tick history filter sit between the
//                       synchroniser and VALUE. When undefined VALUE follows
//                       the synchroniser output directly and TICK_DIV is only
//                       range-checked.
// ----------------------------------------------------------------------------
module switch_bank_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'hE0,
    parameter int         NUM_BANKS = 2,
    parameter int         TICK_DIV  = 1000
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [8*NUM_BANKS-1:0] SWITCHES,
    inout  wire  [7:0]             BUS_DATA,
    switch_bank_ctrl_if.slave      bus
);

    localparam int         W        = 8 * NUM_BANKS;
    localparam logic [7:0] WIN_SIZE = 8'(3 * NUM_BANKS);

    generate
        if (NUM_BANKS < 1 || NUM_BANKS > 4) begin : g_bad_banks
            $error("switch_bank_ctrl: NUM_BANKS must be 1..4");
        end
        if (TICK_DIV < 2) begin : g_bad_tick
            $error("switch_bank_ctrl: TICK_DIV must be at least 2");
        end
    endgenerate

    // ---- stage p0/p1: two-flop synchroniser ----
    logic [W-1:0] sync_p0;
    logic [W-1:0] sync_p1;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= SWITCHES;
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage p2: filter into VALUE ----
    logic [W-1:0] value_q;
    logic [W-1:0] value_next;

`ifdef SWITCH_DEBOUNCE_EN
    localparam int                CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]  presc_q;
    logic              tick;
    logic [3:0][W-1:0] hist_q;
    logic [3:0][W-1:0] hist_next;
    logic [W-1:0]      all_ones;
    logic [W-1:0]      all_zeros;

    assign tick = (presc_q == CNT_MAX);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // The decision looks at the history including the sample shifted in on
    // this tick, so VALUE moves on the same edge as the 4th matching sample.
    assign hist_next = {hist_q[2:0], sync_p1};
    assign all_ones  = hist_next[0] & hist_next[1] & hist_next[2] & hist_next[3];
    assign all_zeros = ~(hist_next[0] | hist_next[1] | hist_next[2] | hist_next[3]);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hist_q <= '0;
        end else if (tick) begin
            hist_q <= hist_next;
        end
    end

    always_comb begin
        value_next = value_q;
        if (tick) begin
            value_next = (value_q | all_ones) & ~all_zeros;
        end
    end
`else
    assign value_next = sync_p1;
`endif

    // Bus decode. The window never wraps past 8'hFF, so an in-window address
    // is simply "at or above BASE_ADDR and within 3*NUM_BANKS of it".
    logic [7:0]   addr_off;
    logic         in_window;
    logic         rd_en;
    logic         wr_en;
    logic [7:0]   rd_data;
    logic [7:0]   wr_data;
    logic [W-1:0] w1c_mask;
    logic [W-1:0] ien_sel;
    logic [W-1:0] ien_next;
    logic [W-1:0] change_q;
    logic [W-1:0] ien_q;
    logic [W-1:0] toggle;
    logic         irq_event;
    logic         pending_q;

    assign addr_off  = bus.BUS_ADDR - BASE_ADDR;
    assign in_window = (bus.BUS_ADDR >= BASE_ADDR) && (addr_off < WIN_SIZE);
    assign rd_en     = in_window && !bus.BUS_WE;
    assign wr_en     = in_window && bus.BUS_WE;
    assign wr_data   = BUS_DATA;
    assign BUS_DATA  = rd_en ? rd_data : 8'hZZ;

    always_comb begin
        rd_data  = 8'h00;
        w1c_mask = '0;
        ien_sel  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (addr_off == 8'(b)) begin
                rd_data = value_q[8*b +: 8];
            end
            if (addr_off == 8'(NUM_BANKS + b)) begin
                rd_data = change_q[8*b +: 8];
                if (wr_en) begin
                    w1c_mask[8*b +: 8] = wr_data;
                end
            end
            if (addr_off == 8'(2*NUM_BANKS + b)) begin
                rd_data = ien_q[8*b +: 8];
                if (wr_en) begin
                    ien_sel[8*b +: 8] = 8'hFF;
                end
            end
        end
    end

    assign ien_next = (ien_q & ~ien_sel) | ({NUM_BANKS{wr_data}} & ien_sel);

    // Events use the IEN value held before this edge, so a simultaneous IEN
    // write never affects the current toggle, and enabling a bit whose CHANGE
    // is already set raises nothing.
    assign toggle    = value_next ^ value_q;
    assign irq_event = |(toggle & ien_q);

    // ---- stage p2 registers: VALUE, CHANGE, IEN, pending ----
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            value_q   <= '0;
            change_q  <= '0;
            ien_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            value_q  <= value_next;
            // Set beats clear when a toggle meets a W1C on the same bit.
            change_q <= (change_q & ~w1c_mask) | toggle;
            ien_q    <= ien_next;
            // A new event beats a coincident acknowledge.
            if (irq_event) begin
                pending_q <= 1'b1;
            end else if (bus.BUS_INTERRUPT_ACK) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign bus.BUS_INTERRUPT_RAISE = pending_q;

endmodule

// File: tb/tb_switch_bank_ctrl.sv
// ----------------------------------------------------------------------------
// tb_switch_bank_ctrl
//
// Directed bench for switch_bank_ctrl (NUM_BANKS=2, BASE_ADDR=8'hE0,
// TICK_DIV=4). The driver pushes each expected read or interrupt level into a
// scoreboard queue and raises a check strobe; an independent monitor pops and
// compares on the falling edge. Exact-edge cases run in the default build;
// glitch filtering runs when SWITCH_DEBOUNCE_EN is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_switch_bank_ctrl;
    localparam int         NB   = 2;
    localparam int         TD   = 4;
    localparam logic [7:0] BASE = 8'hE0;
`ifdef SWITCH_DEBOUNCE_EN
    localparam int SETTLE = 4*TD + 4;
`else
    localparam int SETTLE = 5;
`endif

    localparam logic [7:0] A_VAL0 = BASE + 8'd0;
    localparam logic [7:0] A_VAL1 = BASE + 8'd1;
    localparam logic [7:0] A_CHG0 = BASE + 8'd2;
    localparam logic [7:0] A_CHG1 = BASE + 8'd3;
    localparam logic [7:0] A_IEN0 = BASE + 8'd4;
    localparam logic [7:0] A_IEN1 = BASE + 8'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw;
    logic        drv_en;
    logic [7:0]  drv_data;
    wire  [7:0]  bus_data;

    switch_bank_ctrl_if bus_if();

    // Undriven bus floats to all-ones through the pulls.
    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup pu (bus_data[i]);
    end

    assign bus_data = drv_en ? drv_data : 8'hzz;

    always #5 clk = ~clk;

    switch_bank_ctrl #(
        .BASE_ADDR (BASE),
        .NUM_BANKS (NB),
        .TICK_DIV  (TD)
    ) dut (
        .CLK      (clk),
        .RESET    (rst_n),
        .SWITCHES (sw),
        .BUS_DATA (bus_data),
        .bus      (bus_if)
    );

    typedef struct {
        string      name;
        logic       is_raise;
        logic [7:0] exp;
    } chk_t;

    chk_t chk_q[$];
    logic chk_vld   = 1'b0;
    int   n_checks  = 0;
    int   n_errors  = 0;

    // Monitor: compares whatever the DUT presents when the strobe is up.
    initial begin : monitor
        chk_t       c;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (chk_vld) begin
                n_checks++;
                if (chk_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL scoreboard: got a check strobe, required a queued expectation");
                end else begin
                    c   = chk_q.pop_front();
                    act = c.is_raise ? {7'b0, bus_if.BUS_INTERRUPT_RAISE} : bus_data;
                    if (act !== c.exp) begin
                        n_errors++;
                        $display("FAIL %s: got %h, required %h", c.name, act, c.exp);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_and_strobe(input string name, input logic is_raise, input logic [7:0] exp);
        chk_t c;
        c.name     = name;
        c.is_raise = is_raise;
        c.exp      = exp;
        chk_q.push_back(c);
        chk_vld = 1'b1;
        @(negedge clk);
        #1 chk_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
        bus_if.BUS_ADDR = addr;
        bus_if.BUS_WE   = 1'b0;
        push_and_strobe(name, 1'b0, exp);
    endtask

    task automatic expect_raise(input logic exp, input string name);
        push_and_strobe(name, 1'b1, {7'b0, exp});
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        bus_if.BUS_ADDR = addr;
        bus_if.BUS_WE   = 1'b1;
        drv_data        = data;
        drv_en          = 1'b1;
        @(posedge clk);
        #1;
        bus_if.BUS_WE   = 1'b0;
        drv_en          = 1'b0;
        bus_if.BUS_ADDR = 8'h00;
    endtask

    task automatic ack_pulse();
        bus_if.BUS_INTERRUPT_ACK = 1'b1;
        @(posedge clk);
        #1;
        bus_if.BUS_INTERRUPT_ACK = 1'b0;
    endtask

    initial begin : driver
        rst_n                    = 1'b0;
        sw                       = 16'hA5C3;
        drv_en                   = 1'b0;
        drv_data                 = 8'h00;
        bus_if.BUS_ADDR          = 8'h00;
        bus_if.BUS_WE            = 1'b0;
        bus_if.BUS_INTERRUPT_ACK = 1'b0;
        tick(3);

        // Reset state while held.
        expect_rd(A_VAL0, 8'h00, "rst_value0");
        expect_raise(1'b0, "rst_raise");
        expect_rd(A_CHG0, 8'h00, "rst_change0");

        // Release: inputs already high become 0->1 toggles, no interrupt.
        rst_n = 1'b1;
        tick(SETTLE);
        expect_rd(A_VAL0, 8'hC3, "boot_value0");
        expect_rd(A_VAL1, 8'hA5, "boot_value1");
        expect_rd(A_CHG0, 8'hC3, "boot_change0");
        expect_rd(A_CHG1, 8'hA5, "boot_change1");
        expect_raise(1'b0, "boot_raise");
        expect_rd(BASE + 8'd6, 8'hFF, "above_window_z");
        expect_rd(BASE - 8'd1, 8'hFF, "below_window_z");

        // W1C partial, then clear all.
        bus_write(A_CHG0, 8'h0F);
        expect_rd(A_CHG0, 8'hC0, "w1c_partial_c3");
        bus_write(A_CHG0, 8'hFF);
        bus_write(A_CHG1, 8'hFF);
        expect_rd(A_CHG0, 8'h00, "w1c_clear0");
        expect_rd(A_CHG1, 8'h00, "w1c_clear1");

        // Flip every bit of bank 0.
        sw = 16'hA53C;
        tick(SETTLE);
        expect_rd(A_VAL0, 8'h3C, "value0_3c");
        expect_rd(A_CHG0, 8'hFF, "change0_ff");
        bus_write(A_CHG0, 8'h0F);
        expect_rd(A_CHG0, 8'hF0, "w1c_low_nibble");

        // VALUE is read-only.
        bus_write(A_VAL0, 8'hFF);
        expect_rd(A_VAL0, 8'h3C, "value_write_ignored");

        // IEN read-back.
        bus_write(A_IEN1, 8'h01);
        expect_rd(A_IEN1, 8'h01, "ien1_rb");
        expect_rd(A_IEN0, 8'h00, "ien0_rb");
        expect_raise(1'b0, "raise_after_ien");

        // Enabled toggle on bit 8 (1 -> 0).
        sw = 16'hA43C;
`ifdef SWITCH_DEBOUNCE_EN
        tick(SETTLE);
        expect_raise(1'b1, "irq_set");
`else
        tick(2);
        expect_raise(1'b0, "irq_before_3rd_edge");
        expect_raise(1'b1, "irq_at_3rd_edge");
`endif
        expect_rd(A_VAL1, 8'hA4, "value1_a4");
        expect_rd(A_CHG1, 8'h01, "change1_bit8");
        ack_pulse();
        expect_raise(1'b0, "ack_clears");

        // Masked toggle on bit 9.
        sw = 16'hA63C;
        tick(SETTLE);
        expect_raise(1'b0, "masked_no_irq");
        expect_rd(A_CHG1, 8'h03, "change1_bit9");

        // Enabling bits whose CHANGE is already set is not retroactive.
        bus_write(A_IEN0, 8'hF0);
        expect_raise(1'b0, "ien_not_retroactive");

`ifdef SWITCH_DEBOUNCE_EN
        // Glitch of exactly 2 ticks on bit 0 is filtered.
        sw = 16'hA63D;
        tick(2*TD);
        sw = 16'hA63C;
        tick(SETTLE);
        expect_rd(A_VAL0, 8'h3C, "glitch_filtered");
        expect_rd(A_CHG0, 8'hF0, "glitch_no_change");
        // Held level passes.
        sw = 16'hA63D;
        tick(SETTLE);
        expect_rd(A_VAL0, 8'h3D, "held_passes");
        expect_rd(A_CHG0, 8'hF1, "held_change");
`else
        // W1C on the same edge bit 0 toggles: set wins.
        sw = 16'hA63D;
        tick(2);
        bus_write(A_CHG0, 8'h01);
        expect_rd(A_CHG0, 8'hF1, "w1c_vs_toggle");

        // IEN write on the toggle edge: old IEN (bit1=0) decides.
        sw = 16'hA63F;
        tick(2);
        bus_write(A_IEN0, 8'hFF);
        expect_raise(1'b0, "ien_same_edge_old0");
        expect_rd(A_IEN0, 8'hFF, "ien0_ff");

        // IEN cleared on the toggle edge: old IEN (bit2=1) still fires.
        sw = 16'hA63B;
        tick(2);
        bus_write(A_IEN0, 8'h00);
        expect_raise(1'b1, "ien_same_edge_old1");
        ack_pulse();
        expect_raise(1'b0, "ack_clears_2");

        // ACK coincident with an enabled toggle: event wins.
        sw = 16'hA73B;
        tick(2);
        ack_pulse();
        expect_raise(1'b1, "event_beats_ack");
        ack_pulse();
        expect_raise(1'b0, "ack_clears_3");

        expect_rd(A_VAL0, 8'h3B, "final_value0");
        expect_rd(A_VAL1, 8'hA7, "final_value1");
        expect_rd(A_CHG0, 8'hF7, "final_change0");
        expect_rd(A_CHG1, 8'h03, "final_change1");
        expect_rd(A_IEN1, 8'h01, "final_ien1");
`endif

        tick(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
